// File: rtl/chopper_pkg.sv
// Shared definitions for the chopper sequencer.
//   state_t            : FSM state encoding, also driven out on the phase port
//   CHOP_WIDTH_DEFAULT : default bit width of time values and the phase counter
package chopper_pkg;

  localparam int CHOP_WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } state_t;

endpackage

// File: rtl/chop_timer.sv
// Loadable down-counter shared by every timed phase of the chopper.
//   clk, resetn : clock, synchronous active-low reset (count returns to 0)
//   i_load      : load i_value this cycle (takes priority over counting)
//   i_value     : value to load
//   o_zero      : count is 0 (the current phase's final cycle)
// The count stops at 0 rather than wrapping.
module chop_timer
  import chopper_pkg::*;
#(
  parameter int WIDTH = CHOP_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/chopper_sequencer.sv
// Chopper sequencer for an H-bridge current regulator.
// Cycle: BLANK (comparator ignored) -> ON (until over_current or max time)
// -> OFF (decay) -> BLANK again while enable stays high, else IDLE.
//   clk, resetn  : clock, synchronous active-low reset
//   enable       : run chopping cycles; dropping it ends BLANK/ON early
//   blank_time   : BLANK length value (phase lasts value+1 cycles)
//   max_on_time  : ON length limit value
//   off_time     : OFF length value
//   over_current : comparator trip, already synchronous to clk
//   bridge_on    : bridge driving (BLANK or ON)
//   decay        : bridge in decay (OFF)
//   phase        : current state, equal to the state register
//   trip         : one-cycle pulse, ON ended by over_current
//   timeout      : one-cycle pulse, ON ended by max_on_time
//   cycle_done   : one-cycle pulse, OFF completed
// Handshake: none; enable is a level, all pulses are single-cycle strobes
// aligned with the first cycle of the state they announce.
module chopper_sequencer
  import chopper_pkg::*;
#(
  parameter int WIDTH = CHOP_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [WIDTH-1:0] blank_time,
  input  logic [WIDTH-1:0] max_on_time,
  input  logic [WIDTH-1:0] off_time,
  input  logic             over_current,
  output logic             bridge_on,
  output logic             decay,
  output logic [1:0]       phase,
  output logic             trip,
  output logic             timeout,
  output logic             cycle_done
);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic [WIDTH-1:0] w_value;
  logic             w_zero;
  logic             w_trip;
  logic             w_timeout;
  logic             w_done;

  chop_timer #(.WIDTH(WIDTH)) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_value (w_value),
    .o_zero  (w_zero)
  );

  // Next-state decision; the timer is loaded only on a phase change so
  // time inputs are sampled exactly once, at entry.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_value   = '0;
    w_trip    = 1'b0;
    w_timeout = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next  = BLANK;
          w_load  = 1'b1;
          w_value = blank_time;
        end
      end
      BLANK: begin
        // over_current is deliberately not looked at here.
        if (!enable) begin
          w_next  = OFF;
          w_load  = 1'b1;
          w_value = off_time;
        end else if (w_zero) begin
          w_next  = ON;
          w_load  = 1'b1;
          w_value = max_on_time;
        end
      end
      ON: begin
        // A disable ends ON silently; a trip outranks a coincident expiry.
        if (!enable || over_current || w_zero) begin
          w_next    = OFF;
          w_load    = 1'b1;
          w_value   = off_time;
          w_trip    = enable && over_current;
          w_timeout = enable && !over_current;
        end
      end
      OFF: begin
        // OFF always runs to completion regardless of enable.
        if (w_zero) begin
          w_done = 1'b1;
          if (enable) begin
            w_next  = BLANK;
            w_load  = 1'b1;
            w_value = blank_time;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      bridge_on  <= 1'b0;
      decay      <= 1'b0;
      trip       <= 1'b0;
      timeout    <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      bridge_on  <= (w_next == BLANK) || (w_next == ON);
      decay      <= (w_next == OFF);
      trip       <= w_trip;
      timeout    <= w_timeout;
      cycle_done <= w_done;
    end
  end

  assign phase = r_state;

endmodule

// File: tb/tb_chopper_sequencer.sv
// Bench for chopper_sequencer: directed timeline scenarios plus a
// randomized run, all checked every cycle against a phase/remaining-cycles
// reference model, with extra checks of event times against fixed cycles.
module tb_chopper_sequencer;

  localparam int W       = 10;
  localparam int P_IDLE  = 0;
  localparam int P_BLANK = 1;
  localparam int P_ON    = 2;
  localparam int P_OFF   = 3;

  // clock / reset / stimulus signals
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b0;
  logic         over_current = 1'b0;
  logic [W-1:0] blank_time = '0;
  logic [W-1:0] max_on_time = '0;
  logic [W-1:0] off_time = '0;
  logic         bridge_on;
  logic         decay;
  logic [1:0]   phase;
  logic         trip;
  logic         timeout;
  logic         cycle_done;

  always #5 clk = ~clk;

  chopper_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .blank_time   (blank_time),
    .max_on_time  (max_on_time),
    .off_time     (off_time),
    .over_current (over_current),
    .bridge_on    (bridge_on),
    .decay        (decay),
    .phase        (phase),
    .trip         (trip),
    .timeout      (timeout),
    .cycle_done   (cycle_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: current phase and cycles remaining in it
  int m_phase   = P_IDLE;
  int m_left    = 0;
  int m_trip    = 0;
  int m_timeout = 0;
  int m_done    = 0;

  // scenario timeline markers (first cycle each event was seen)
  int t;
  int trip_at;
  int timeout_at;
  int done_at;
  int on_at;
  int blank_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit last;
    m_trip    = 0;
    m_timeout = 0;
    m_done    = 0;
    if (!resetn) begin
      m_phase = P_IDLE;
      m_left  = 0;
      return;
    end
    last = (m_left == 1);
    case (m_phase)
      P_IDLE: begin
        if (enable) begin
          m_phase = P_BLANK;
          m_left  = int'(blank_time) + 1;
        end
      end
      P_BLANK: begin
        if (!enable) begin
          m_phase = P_OFF;
          m_left  = int'(off_time) + 1;
        end else if (last) begin
          m_phase = P_ON;
          m_left  = int'(max_on_time) + 1;
        end else m_left--;
      end
      P_ON: begin
        if (!enable) begin
          m_phase = P_OFF;
          m_left  = int'(off_time) + 1;
        end else if (over_current) begin
          m_phase = P_OFF;
          m_left  = int'(off_time) + 1;
          m_trip  = 1;
        end else if (last) begin
          m_phase   = P_OFF;
          m_left    = int'(off_time) + 1;
          m_timeout = 1;
        end else m_left--;
      end
      default: begin
        if (last) begin
          m_done = 1;
          if (enable) begin
            m_phase = P_BLANK;
            m_left  = int'(blank_time) + 1;
          end else begin
            m_phase = P_IDLE;
            m_left  = 0;
          end
        end else m_left--;
      end
    endcase
  endtask

  // One clock: inputs already set for cycle t; observe cycle t+1.
  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    t++;
    chk("phase", 32'(phase), m_phase);
    chk("bridge_on", 32'(bridge_on), (m_phase == P_BLANK || m_phase == P_ON) ? 1 : 0);
    chk("decay", 32'(decay), (m_phase == P_OFF) ? 1 : 0);
    chk("trip", 32'(trip), m_trip);
    chk("timeout", 32'(timeout), m_timeout);
    chk("cycle_done", 32'(cycle_done), m_done);
    if (trip === 1'b1 && trip_at < 0) trip_at = t;
    if (timeout === 1'b1 && timeout_at < 0) timeout_at = t;
    if (cycle_done === 1'b1 && done_at < 0) done_at = t;
    if (phase === 2'd2 && on_at < 0) on_at = t;
    if (phase === 2'd1) blank_len++;
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    enable       = 1'b0;
    over_current = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic start_scn(input int bt, input int mt, input int ot);
    blank_time  = W'(bt);
    max_on_time = W'(mt);
    off_time    = W'(ot);
    t           = 0;
    trip_at     = -1;
    timeout_at  = -1;
    done_at     = -1;
    on_at       = -1;
    blank_len   = 0;
  endtask

  initial begin
    // reset state, then idle hold with enable low
    start_scn(3, 10, 5);
    do_reset();
    chk("reset_phase", 32'(phase), P_IDLE);
    for (int c = 0; c < 10; c++) begin
      over_current = 1'($urandom_range(0, 1));
      blank_time   = W'($urandom_range(0, 7));
      step();
    end
    chk("idle_hold_phase", 32'(phase), P_IDLE);

    // over_current pulse in ON; time inputs changed mid-phase
    do_reset();
    start_scn(3, 10, 5);
    for (int c = 0; c <= 13; c++) begin
      enable       = 1'b1;
      over_current = (c == 7);
      if (c == 9) begin
        off_time    = W'(1);
        max_on_time = W'(2);
      end
      if (c == 12) blank_time = W'(3);
      step();
    end
    chk("s1_on_at", on_at, 5);
    chk("s1_trip_at", trip_at, 8);
    chk("s1_done_at", done_at, 14);
    chk("s1_blank14", 32'(phase), P_BLANK);

    // no over_current: ON runs out
    do_reset();
    start_scn(3, 10, 5);
    for (int c = 0; c <= 21; c++) begin
      enable       = 1'b1;
      over_current = 1'b0;
      step();
    end
    chk("s2_timeout_at", timeout_at, 16);
    chk("s2_done_at", done_at, 22);
    chk("s2_no_trip", trip_at, -1);

    // over_current held through BLANK is ignored
    do_reset();
    start_scn(3, 10, 5);
    for (int c = 0; c <= 6; c++) begin
      enable       = 1'b1;
      over_current = (c >= 1 && c <= 5);
      step();
    end
    chk("s3_on_at", on_at, 5);
    chk("s3_trip_at", trip_at, 6);

    // enable dropped during ON
    do_reset();
    start_scn(3, 10, 5);
    for (int c = 0; c <= 13; c++) begin
      enable       = (c < 6);
      over_current = 1'b0;
      step();
    end
    chk("s4_no_trip", trip_at, -1);
    chk("s4_no_timeout", timeout_at, -1);
    chk("s4_done_at", done_at, 13);
    chk("s4_idle14", 32'(phase), P_IDLE);

    // reset mid-ON, then zero-length BLANK
    do_reset();
    start_scn(3, 10, 5);
    for (int c = 0; c <= 9; c++) begin
      enable = 1'b1;
      resetn = (c != 9);
      step();
    end
    resetn = 1'b1;
    chk("s5_rst_phase", 32'(phase), P_IDLE);
    chk("s5_rst_bridge", 32'(bridge_on), 0);
    chk("s5_rst_decay", 32'(decay), 0);
    start_scn(0, 10, 5);
    for (int c = 0; c <= 3; c++) begin
      enable = 1'b1;
      step();
    end
    chk("s5_blank_len", blank_len, 1);
    chk("s5_on_at", on_at, 2);

    // over_current on ON's final cycle: trip only
    do_reset();
    start_scn(3, 10, 5);
    for (int c = 0; c <= 15; c++) begin
      enable       = 1'b1;
      over_current = (c == 15);
      step();
    end
    chk("s6_trip_at", trip_at, 16);
    chk("s6_no_timeout", timeout_at, -1);

    // full-scale ON time
    do_reset();
    start_scn(0, 1023, 0);
    for (int c = 0; c <= 1025; c++) begin
      enable       = 1'b1;
      over_current = 1'b0;
      step();
    end
    chk("s7_timeout_at", timeout_at, 1026);

    // randomized run
    do_reset();
    start_scn(0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      resetn       = ($urandom_range(0, 199) != 0);
      enable       = ($urandom_range(0, 15) != 0);
      over_current = ($urandom_range(0, 7) == 0);
      blank_time   = W'($urandom_range(0, 6));
      max_on_time  = W'($urandom_range(0, 12));
      off_time     = W'($urandom_range(0, 6));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
